if_fetch_buffer: RTL and testbench



---
 rtl/if_fetch_buffer.sv | 127 ++++++++++++
 tb/tb_if_fetch_buffer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_buffer
// Purpose  : Fetch-stage buffer between the PC register and decode. Issues
//            reads to a 1-cycle synchronous instruction ROM, captures each
//            returned instruction with its PC into a DEPTH-entry FIFO and
//            presents the head entry to decode over valid/ready.
// Ports    : clk, reset_n          - clock, synchronous active-low reset
//            if_pc, if_ce          - fetch address / request from PC register
//            flush                 - drop all queued and in-flight fetches
//            rom_ce, rom_addr      - ROM read issue
//            rom_inst              - ROM data, valid the cycle after rom_ce
//            id_valid, id_ready    - decode handshake
//            id_pc, id_inst        - head entry (zero when empty)
//            fetch_stall           - PC register must hold if_pc
//            fifo_count            - current occupancy
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch_buffer #(
    parameter int DEPTH = 2,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [AW-1:0]                if_pc,
    input  logic                         if_ce,
    input  logic                         flush,
    output logic                         rom_ce,
    output logic [AW-1:0]                rom_addr,
    input  logic [DW-1:0]                rom_inst,
    output logic                         id_valid,
    input  logic                         id_ready,
    output logic [AW-1:0]                id_pc,
    output logic [DW-1:0]                id_inst,
    output logic                         fetch_stall,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

    localparam int              c_cw    = $clog2(DEPTH + 1);
    localparam int              c_pw    = $clog2(DEPTH);
    localparam logic [c_cw:0]   c_depth = (c_cw + 1)'(DEPTH);
    localparam logic [c_cw-1:0] c_full  = c_cw'(DEPTH);

    logic [AW-1:0]   r_pc_mem   [DEPTH];
    logic [DW-1:0]   r_inst_mem [DEPTH];
    logic [c_cw-1:0] r_count;
    logic [c_pw-1:0] r_rd_ptr;
    logic [c_pw-1:0] r_wr_ptr;
    logic            r_inflight;
    logic [AW-1:0]   r_pc_d1;

    logic            w_pop;
    logic            w_push;
    logic            w_issue;
    logic [c_cw:0]   w_occ;

    assign id_valid = (r_count != '0);
    assign w_pop    = id_valid & id_ready;
    assign w_push   = r_inflight & ~flush;

    // Credit check includes the in-flight slot so a landing read always has
    // room. Subtracting the same-cycle pop keeps full-rate streaming; this
    // makes rom_ce depend combinationally on id_ready.
    assign w_occ    = {1'b0, r_count} + (c_cw + 1)'(r_inflight) - (c_cw + 1)'(w_pop);
    assign w_issue  = reset_n & if_ce & ~flush & (w_occ < c_depth);

    assign rom_ce      = w_issue;
    assign rom_addr    = if_pc;
    assign fetch_stall = reset_n & if_ce & ~w_issue & ~flush;
    assign fifo_count  = r_count;

    // Empty queue presents a zero PC and a zero (NOP) instruction.
    assign id_pc   = id_valid ? r_pc_mem[r_rd_ptr]   : '0;
    assign id_inst = id_valid ? r_inst_mem[r_rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_inflight <= 1'b0;
            r_pc_d1    <= '0;
        end else if (flush) begin
            // The in-flight read is forgotten, so its data is never written.
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_pc_d1 <= if_pc;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible through r_count.
    always_ff @(posedge clk) begin
        if (reset_n && w_push) begin
            r_pc_mem[r_wr_ptr]   <= r_pc_d1;
            r_inst_mem[r_wr_ptr] <= rom_inst;
        end
    end

`ifndef SYNTHESIS
    a_count_le_depth : assert property (@(posedge clk) disable iff (!reset_n)
        r_count <= c_full);
    a_credit_bound   : assert property (@(posedge clk) disable iff (!reset_n)
        ({1'b0, r_count} + (c_cw + 1)'(r_inflight)) <= c_depth);
    a_no_push_full   : assert property (@(posedge clk) disable iff (!reset_n)
        (w_push && (r_count == c_full)) |-> w_pop);
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch_buffer
// Purpose  : Directed self-checking bench for if_fetch_buffer (DEPTH=2).
//            A behavioural ROM returns addr|0xA000_0000 one cycle after
//            rom_ce; an expected-PC queue tracks what decode must receive.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch_buffer;

    localparam int DEPTH = 2;

    logic        clk;
    logic        reset_n;
    logic [31:0] if_pc;
    logic        if_ce;
    logic        flush;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        fetch_stall;
    logic [1:0]  fifo_count;

    int          n_tests;
    int          n_fail;
    logic [31:0] exp_q[$];

    if_fetch_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .if_pc       (if_pc),
        .if_ce       (if_ce),
        .flush       (flush),
        .rom_ce      (rom_ce),
        .rom_addr    (rom_addr),
        .rom_inst    (rom_inst),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_pc       (id_pc),
        .id_inst     (id_inst),
        .fetch_stall (fetch_stall),
        .fifo_count  (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM: garbage when not enabled so stale data is visible.
    always @(posedge clk) begin
        rom_inst <= rom_ce ? (rom_addr | 32'hA000_0000) : 32'hDEAD_BEEF;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Any handshake this cycle must deliver the oldest expected PC.
    task automatic deliver();
        if (id_valid && id_ready) begin
            if (exp_q.size() == 0) begin
                check("no_stray_delivery", {63'b0, id_valid}, 64'd0);
            end else begin
                check("deliver_pc", {32'b0, id_pc}, {32'b0, exp_q[0]});
                check("deliver_inst", {32'b0, id_inst}, {32'b0, exp_q[0] | 32'hA000_0000});
                void'(exp_q.pop_front());
            end
        end
    endtask

    task automatic drive(input logic ce, input logic [31:0] pc, input logic rdy, input logic exp_issue);
        if_ce    = ce;
        if_pc    = pc;
        id_ready = rdy;
        flush    = 1'b0;
        #1;
        check("rom_ce", {63'b0, rom_ce}, {63'b0, exp_issue});
        check("fetch_stall", {63'b0, fetch_stall}, {63'b0, ce & ~exp_issue});
        if (exp_issue) begin
            check("rom_addr", {32'b0, rom_addr}, {32'b0, pc});
            exp_q.push_back(pc);
        end
        deliver();
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        if_ce    = 1'b1;
        id_ready = 1'b1;
        flush    = 1'b0;
        if_pc    = 32'h0;

        // Reset held 3 cycles with requests pending.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_rom_ce", {63'b0, rom_ce}, 64'd0);
            check("rst_stall", {63'b0, fetch_stall}, 64'd0);
            check("rst_valid", {63'b0, id_valid}, 64'd0);
            check("rst_inst", {32'b0, id_inst}, 64'd0);
            check("rst_count", {62'b0, fifo_count}, 64'd0);
        end
        reset_n = 1'b1;
        check("rst_pc", {32'b0, id_pc}, 64'd0);

        // Streaming: first issue right after reset release, delivery 2 later.
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 32'(4 * k), 1'b1, 1'b1);
            check("stream_valid", {63'b0, id_valid}, (k < 2) ? 64'd0 : 64'd1);
            tick();
        end
        // Queue now: 24 buffered, 28 in flight.

        // Back-pressure: FIFO fills, issue stops, head frozen.
        drive(1'b1, 32'd32, 1'b0, 1'b0);
        check("bp_count0", {62'b0, fifo_count}, 64'd1);
        check("bp_head0", {32'b0, id_pc}, 64'd24);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'd32, 1'b0, 1'b0);
            check("bp_count_full", {62'b0, fifo_count}, 64'd2);
            check("bp_head_frozen", {32'b0, id_pc}, 64'd24);
            check("bp_inst_frozen", {32'b0, id_inst}, 64'hA000_0018);
            tick();
        end
        // Release: 32 issues in the same cycle as the pop that frees room.
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 32'(32 + 4 * k), 1'b1, 1'b1);
            tick();
        end
        // Queue now: 48 buffered, 52 in flight.

        // Put 0x10 in flight behind a full-credit queue.
        drive(1'b1, 32'h10, 1'b1, 1'b1);
        tick();
        check("pre_flush_count", {62'b0, fifo_count}, 64'd1);

        // Flush: pop of 52 in this cycle is still consumed by decode.
        if_ce    = 1'b1;
        if_pc    = 32'h20;
        id_ready = 1'b1;
        flush    = 1'b1;
        #1;
        check("flush_rom_ce", {63'b0, rom_ce}, 64'd0);
        check("flush_stall", {63'b0, fetch_stall}, 64'd0);
        check("flush_head", {32'b0, id_pc}, 64'h34);
        deliver();
        exp_q.delete();
        tick();
        flush = 1'b0;
        check("post_flush_valid", {63'b0, id_valid}, 64'd0);
        check("post_flush_count", {62'b0, fifo_count}, 64'd0);
        check("post_flush_pc", {32'b0, id_pc}, 64'd0);
        drive(1'b1, 32'h100, 1'b1, 1'b1);
        tick();
        drive(1'b1, 32'h104, 1'b1, 1'b1);
        check("flush_drop", {62'b0, fifo_count}, 64'd0);
        tick();
        drive(1'b1, 32'h108, 1'b1, 1'b1);
        check("flush_first_valid", {63'b0, id_valid}, 64'd1);
        check("flush_first_pc", {32'b0, id_pc}, 64'h100);
        tick();

        // Fill to 2, then reset mid-stream.
        drive(1'b1, 32'h10C, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h10C, 1'b0, 1'b0);
        check("pre_rst_count", {62'b0, fifo_count}, 64'd2);
        tick();
        reset_n  = 1'b0;
        id_ready = 1'b1;
        #1;
        check("midrst_rom_ce", {63'b0, rom_ce}, 64'd0);
        check("midrst_stall", {63'b0, fetch_stall}, 64'd0);
        tick();
        reset_n = 1'b1;
        exp_q.delete();
        check("midrst_count", {62'b0, fifo_count}, 64'd0);
        check("midrst_valid", {63'b0, id_valid}, 64'd0);
        check("midrst_pc", {32'b0, id_pc}, 64'd0);

        // Gapped fetch: only if_ce=1 cycles issue, never a stall.
        drive(1'b1, 32'h200, 1'b1, 1'b1); tick();
        drive(1'b0, 32'h204, 1'b1, 1'b0); tick();
        drive(1'b1, 32'h208, 1'b1, 1'b1); tick();
        drive(1'b0, 32'h20C, 1'b1, 1'b0); tick();
        drive(1'b1, 32'h210, 1'b1, 1'b1); tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'h214, 1'b1, 1'b0);
            tick();
        end
        check("drain_count", {62'b0, fifo_count}, 64'd0);
        check("drain_all_delivered", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
